// File: rtl/reg_trace_pkg.sv
// Shared types, reset values and width helpers for the register-write tracer.
// Revision: 1.0 - initial release
`default_nettype none

package reg_trace_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_SEQ_W  = 16;

  // Trace record at the default widths; the top builds a local struct of the
  // same shape when its widths are overridden.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_SEQ_W-1:0]  seq;
  } trace_entry_t;

  localparam logic RST_SHADOW_BIT = 1'b0;
  localparam logic RST_DIRTY_BIT  = 1'b0;
  localparam logic RST_SEQ_BIT    = 1'b0;
  localparam logic RST_OVERFLOW   = 1'b0;

  function automatic int addr_width(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with pointer+count bookkeeping.
// Revision: 1.0 - initial release
`default_nettype none

module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  T                 mem_q [DEPTH];

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/reg_write_tracer.sv
// Observes the register-write port: shadow register file, dirty mask and a
// sequence-tagged trace FIFO with sticky overflow reporting.
// Revision: 1.0 - initial release
`default_nettype none

module reg_write_tracer
  import reg_trace_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int NUM_REGS      = 32,
  parameter int ADDR_W        = 5,
  parameter int TRACE_DEPTH   = 16,
  parameter int SEQ_W         = 16,
  parameter bit SKIP_ZERO_REG = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         clear_dirty,
  input  logic [ADDR_W-1:0]            shadow_raddr,
  output logic [DATA_W-1:0]            shadow_rdata,
  output logic [NUM_REGS-1:0]          dirty_mask,
  output logic                         trace_valid,
  input  logic                         trace_ready,
  output logic [ADDR_W-1:0]            trace_addr,
  output logic [DATA_W-1:0]            trace_data,
  output logic [SEQ_W-1:0]             trace_seq,
  output logic [$clog2(TRACE_DEPTH):0] trace_count,
  output logic                         overflow
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SEQ_W-1:0]  seq;
  } entry_t;

  generate
    if (ADDR_W != addr_width(NUM_REGS)) begin : g_addr_w_check
      $error("ADDR_W does not match NUM_REGS");
    end
  endgenerate

  logic              waddr_ok, raddr_ok;
  logic              accept, pop_fire, fifo_full;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_d [NUM_REGS];
  logic [DATA_W-1:0] shadow_rdata_q, shadow_rdata_d;
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              overflow_q, overflow_d;
  entry_t            push_entry, head_entry;

  // Range checks collapse to constants when the address space is fully populated.
  generate
    if (NUM_REGS == (1 << ADDR_W)) begin : g_full_range
      assign waddr_ok = 1'b1;
      assign raddr_ok = 1'b1;
    end else begin : g_partial_range
      assign waddr_ok = (32'(wr_addr) < NUM_REGS);
      assign raddr_ok = (32'(shadow_raddr) < NUM_REGS);
    end
  endgenerate

  always_comb begin
    accept   = wr_valid && waddr_ok && !(SKIP_ZERO_REG && (wr_addr == '0));
    pop_fire = trace_valid && trace_ready;

    shadow_d = shadow_q;
    if (accept) shadow_d[wr_addr] = wr_data;

    dirty_d = clear_dirty ? {NUM_REGS{RST_DIRTY_BIT}} : dirty_q;
    if (accept) dirty_d[wr_addr] = 1'b1;

    // Sequence advances on every accepted write, dropped or not.
    seq_d      = seq_q + SEQ_W'(accept);
    overflow_d = overflow_q || (accept && fifo_full && !pop_fire);

    if (!raddr_ok)
      shadow_rdata_d = '0;
    else if (accept && (wr_addr == shadow_raddr))
      shadow_rdata_d = wr_data;
    else
      shadow_rdata_d = shadow_q[shadow_raddr];

    push_entry = '{addr: wr_addr, data: wr_data, seq: seq_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= {DATA_W{RST_SHADOW_BIT}};
      shadow_rdata_q <= {DATA_W{RST_SHADOW_BIT}};
      dirty_q        <= {NUM_REGS{RST_DIRTY_BIT}};
      seq_q          <= {SEQ_W{RST_SEQ_BIT}};
      overflow_q     <= RST_OVERFLOW;
    end else begin
      shadow_q       <= shadow_d;
      shadow_rdata_q <= shadow_rdata_d;
      dirty_q        <= dirty_d;
      seq_q          <= seq_d;
      overflow_q     <= overflow_d;
    end
  end

  sync_fifo #(
    .T     (entry_t),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (push_entry),
    .pop   (trace_ready),
    .dout  (head_entry),
    .valid (trace_valid),
    .full  (fifo_full),
    .count (trace_count)
  );

  assign trace_addr   = head_entry.addr;
  assign trace_data   = head_entry.data;
  assign trace_seq    = head_entry.seq;
  assign shadow_rdata = shadow_rdata_q;
  assign dirty_mask   = dirty_q;
  assign overflow     = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_tracer.sv
// Directed self-checking bench for reg_write_tracer at default parameters.
// Revision: 1.0 - initial release
`default_nettype none

module tb_reg_write_tracer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clear_dirty;
  logic [4:0]  shadow_raddr;
  logic [31:0] shadow_rdata;
  logic [31:0] dirty_mask;
  logic        trace_valid;
  logic        trace_ready;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;
  logic [15:0] trace_seq;
  logic [4:0]  trace_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_write_tracer dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .clear_dirty  (clear_dirty),
    .shadow_raddr (shadow_raddr),
    .shadow_rdata (shadow_rdata),
    .dirty_mask   (dirty_mask),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_addr   (trace_addr),
    .trace_data   (trace_data),
    .trace_seq    (trace_seq),
    .trace_count  (trace_count),
    .overflow     (overflow)
  );

  // Advance one rising edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; clear_dirty = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    wr_addr = '0; wr_data = '0; shadow_raddr = '0; trace_ready = 1'b0;
    do_reset();
    step();
    checks++;
    if (trace_valid !== 1'b0 || trace_count !== 5'd0) begin
      errors++; $display("FAIL reset_fifo valid=%b count=%0d want 0/0", trace_valid, trace_count);
    end
    checks++;
    if (dirty_mask !== 32'h0 || overflow !== 1'b0 || shadow_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_state dirty=%h ovf=%b rdata=%h want 0", dirty_mask, overflow, shadow_rdata);
    end
  endtask

  task automatic test_basic_write();
    trace_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step();
    wr_valid = 1'b0;
    checks++;
    if (trace_valid !== 1'b1 || trace_addr !== 5'd5 || trace_data !== 32'hDEADBEEF || trace_seq !== 16'd0) begin
      errors++; $display("FAIL basic_head v=%b a=%0d d=%h s=%0d want 1/5/deadbeef/0",
                         trace_valid, trace_addr, trace_data, trace_seq);
    end
    checks++;
    if (dirty_mask !== 32'h20) begin
      errors++; $display("FAIL basic_dirty got %h want 00000020", dirty_mask);
    end
    step();
    checks++;
    if (trace_valid !== 1'b0 || trace_count !== 5'd0) begin
      errors++; $display("FAIL basic_pop valid=%b count=%0d want 0/0", trace_valid, trace_count);
    end
  endtask

  task automatic test_skip_zero();
    trace_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; shadow_raddr = 5'd0;
    step();
    wr_valid = 1'b0;
    checks++;
    if (trace_valid !== 1'b0 || dirty_mask !== 32'h20 || shadow_rdata !== 32'h0) begin
      errors++; $display("FAIL skip_zero valid=%b dirty=%h rdata=%h want 0/00000020/0",
                         trace_valid, dirty_mask, shadow_rdata);
    end
    wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 32'h11;
    step();
    wr_valid = 1'b0;
    checks++;
    if (trace_valid !== 1'b1 || trace_seq !== 16'd1 || trace_addr !== 5'd1) begin
      errors++; $display("FAIL skip_zero_seq v=%b s=%0d a=%0d want 1/1/1", trace_valid, trace_seq, trace_addr);
    end
    step();
  endtask

  task automatic test_back_to_back();
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 5'(7 + i); wr_data = 32'h100 + 32'(i);
      step();
      checks++;
      if (trace_count !== 5'd1 || trace_seq !== 16'(2 + i) || trace_data !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL b2b_%0d count=%0d seq=%0d data=%h want 1/%0d/%h",
                           i, trace_count, trace_seq, trace_data, 2 + i, 32'h100 + 32'(i));
      end
    end
    wr_valid = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1; wr_addr = 5'(i + 1); wr_data = 32'(i);
      step();
    end
    wr_valid = 1'b0;
    checks++;
    if (trace_count !== 5'd16 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_full count=%0d ovf=%b want 16/1", trace_count, overflow);
    end
    trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (trace_valid !== 1'b1 || trace_seq !== 16'(i) || trace_addr !== 5'(i + 1)) begin
        errors++; $display("FAIL ovf_drain_%0d v=%b seq=%0d addr=%0d want 1/%0d/%0d",
                           i, trace_valid, trace_seq, trace_addr, i, i + 1);
      end
      step();
    end
    wr_valid = 1'b1; wr_addr = 5'd2; wr_data = 32'hAA;
    step();
    wr_valid = 1'b0;
    checks++;
    if (trace_valid !== 1'b1 || trace_seq !== 16'd17 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_gap v=%b seq=%0d ovf=%b want 1/17/1", trace_valid, trace_seq, overflow);
    end
    step();
  endtask

  task automatic test_full_push_pop();
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_addr = 5'(i + 1); wr_data = 32'h200 + 32'(i);
      step();
    end
    trace_ready = 1'b1; wr_addr = 5'd20; wr_data = 32'h2FF;
    step();
    wr_valid = 1'b0; trace_ready = 1'b0;
    checks++;
    if (trace_count !== 5'd16 || overflow !== 1'b0 || trace_seq !== 16'd1) begin
      errors++; $display("FAIL full_pp count=%0d ovf=%b head_seq=%0d want 16/0/1", trace_count, overflow, trace_seq);
    end
    trace_ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (trace_count !== 5'd1 || trace_seq !== 16'd16 || trace_data !== 32'h2FF || trace_addr !== 5'd20) begin
      errors++; $display("FAIL full_pp_last count=%0d seq=%0d data=%h addr=%0d want 1/16/2ff/20",
                         trace_count, trace_seq, trace_data, trace_addr);
    end
    step();
  endtask

  task automatic test_clear_dirty();
    trace_ready = 1'b1;
    clear_dirty = 1'b1; wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE0003; shadow_raddr = 5'd3;
    step();
    clear_dirty = 1'b0; wr_valid = 1'b0;
    checks++;
    if (dirty_mask !== 32'h8) begin
      errors++; $display("FAIL clear_write dirty=%h want 00000008", dirty_mask);
    end
    checks++;
    if (shadow_rdata !== 32'hCAFE0003) begin
      errors++; $display("FAIL bypass rdata=%h want cafe0003", shadow_rdata);
    end
    shadow_raddr = 5'd20;
    step();
    checks++;
    if (shadow_rdata !== 32'h2FF) begin
      errors++; $display("FAIL shadow_read r20=%h want 000002ff", shadow_rdata);
    end
    clear_dirty = 1'b1;
    step();
    clear_dirty = 1'b0;
    checks++;
    if (dirty_mask !== 32'h0) begin
      errors++; $display("FAIL clear_only dirty=%h want 0", dirty_mask);
    end
  endtask

  task automatic test_reset_mid();
    int nonzero;
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = 5'(i + 8); wr_data = 32'h300 + 32'(i);
      step();
    end
    wr_valid = 1'b0;
    checks++;
    if (trace_count !== 5'd8) begin
      errors++; $display("FAIL mid_fill count=%0d want 8", trace_count);
    end
    do_reset();
    checks++;
    if (trace_valid !== 1'b0 || trace_count !== 5'd0 || overflow !== 1'b0 || dirty_mask !== 32'h0) begin
      errors++; $display("FAIL mid_reset v=%b count=%0d ovf=%b dirty=%h want 0/0/0/0",
                         trace_valid, trace_count, overflow, dirty_mask);
    end
    nonzero = 0;
    for (int r = 0; r < 32; r++) begin
      shadow_raddr = 5'(r);
      step();
      if (shadow_rdata !== 32'h0) nonzero++;
    end
    checks++;
    if (nonzero !== 0) begin
      errors++; $display("FAIL mid_shadow nonzero_regs=%0d want 0", nonzero);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_skip_zero();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_clear_dirty();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
